// File: rtl/seven_seg_scanner_pkg.sv
// rtl/seven_seg_scanner_pkg.sv - glyph constants and width helper for the seven-segment scanner
package seven_seg_scanner_pkg;

   localparam logic [6:0] SEG_0   = 7'b0000001;
   localparam logic [6:0] SEG_1   = 7'b1001111;
   localparam logic [6:0] SEG_2   = 7'b0010010;
   localparam logic [6:0] SEG_3   = 7'b0000110;
   localparam logic [6:0] SEG_4   = 7'b1001100;
   localparam logic [6:0] SEG_5   = 7'b0100100;
   localparam logic [6:0] SEG_6   = 7'b0100000;
   localparam logic [6:0] SEG_7   = 7'b0001111;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0000100;
   localparam logic [6:0] SEG_A   = 7'b0001000;
   localparam logic [6:0] SEG_B   = 7'b1100000;
   localparam logic [6:0] SEG_C   = 7'b0110001;
   localparam logic [6:0] SEG_D   = 7'b1000010;
   localparam logic [6:0] SEG_E   = 7'b0110000;
   localparam logic [6:0] SEG_F   = 7'b0111000;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Counter widths never collapse to zero bits, even for a single digit.
   function automatic int clog2_min1(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// rtl/seven_seg_scanner_if.sv - data-in / display-pins bundle between datapath and scanner
interface seven_seg_scanner_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    load;
   logic                    blank_lz;
   logic [6:0]              seg_n;
   logic                    dp_n;
   logic [NUM_DIGITS-1:0]   an_n;
   logic                    frame_start;

   modport master (
      output value, dp_in, load, blank_lz,
      input  seg_n, dp_n, an_n, frame_start
   );

   modport slave (
      input  value, dp_in, load, blank_lz,
      output seg_n, dp_n, an_n, frame_start
   );
endinterface

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// rtl/seven_seg_scanner_hex_to_seg.sv - nibble to active-low {a..g} segment pattern
module hex_to_seg
   import seven_seg_scanner_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_n_o
);

   always_comb begin
      seg_n_o = SEG_OFF;
      case (nibble_i)
         4'h0:    seg_n_o = SEG_0;
         4'h1:    seg_n_o = SEG_1;
         4'h2:    seg_n_o = SEG_2;
         4'h3:    seg_n_o = SEG_3;
         4'h4:    seg_n_o = SEG_4;
         4'h5:    seg_n_o = SEG_5;
         4'h6:    seg_n_o = SEG_6;
         4'h7:    seg_n_o = SEG_7;
         4'h8:    seg_n_o = SEG_8;
         4'h9:    seg_n_o = SEG_9;
         4'hA:    seg_n_o = SEG_A;
         4'hB:    seg_n_o = SEG_B;
         4'hC:    seg_n_o = SEG_C;
         4'hD:    seg_n_o = SEG_D;
         4'hE:    seg_n_o = SEG_E;
         4'hF:    seg_n_o = SEG_F;
         default: seg_n_o = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed common-anode display driver with frame-synchronous shadow update
module seven_seg_scanner
   import seven_seg_scanner_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD       = 2
) (
   input  logic               clk,
   input  logic               reset,
   seven_seg_scanner_if.slave bus
);

   localparam int IDX_W = clog2_min1(NUM_DIGITS);
   localparam int PRE_W = clog2_min1(REFRESH_DIV);
   localparam int VAL_W = 4 * NUM_DIGITS;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [PRE_W-1:0] GUARD_C  = PRE_W'(GUARD);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [PRE_W-1:0]      presc_q, presc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [VAL_W-1:0]      pend_val_q, pend_val_d, sh_val_q, sh_val_d;
   logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, sh_dp_q, sh_dp_d;
   logic                  pend_blz_q, pend_blz_d, sh_blz_q, sh_blz_d;
   logic                  pend_flag_q, pend_flag_d;
   logic [6:0]            seg_n_q, seg_n_d;
   logic                  dp_n_q, dp_n_d;
   logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
   logic                  wrap_q, wrap_d;
   logic                  frame_start_q, frame_start_d;

   logic                  tick, wrap;
   logic [NUM_DIGITS-1:0] blank_mask;
   logic [3:0]            cur_nibble;
   logic [6:0]            cur_seg_n;

   hex_to_seg u_hex_to_seg (
      .nibble_i (cur_nibble),
      .seg_n_o  (cur_seg_n)
   );

   always_comb begin
      blank_mask = '0;
      for (int k = 1; k < NUM_DIGITS; k++) begin
         blank_mask[k] = sh_blz_q && ((sh_val_q >> (4 * k)) == '0);
      end
   end

   assign cur_nibble = sh_val_q[idx_q*4 +: 4];

   always_comb begin
      tick    = (presc_q == PRE_LAST);
      wrap    = tick && (idx_q == IDX_LAST);
      presc_d = tick ? '0 : presc_q + 1'b1;
      idx_d   = idx_q;
      if (tick) begin
         idx_d = wrap ? '0 : idx_q + 1'b1;
      end

      pend_val_d  = pend_val_q;
      pend_dp_d   = pend_dp_q;
      pend_blz_d  = pend_blz_q;
      pend_flag_d = pend_flag_q;
      sh_val_d    = sh_val_q;
      sh_dp_d     = sh_dp_q;
      sh_blz_d    = sh_blz_q;

      // A load landing on the boundary goes straight to the shadow; pending is stale then.
      if (wrap && bus.load) begin
         sh_val_d    = bus.value;
         sh_dp_d     = bus.dp_in;
         sh_blz_d    = bus.blank_lz;
         pend_flag_d = 1'b0;
      end else if (bus.load) begin
         pend_val_d  = bus.value;
         pend_dp_d   = bus.dp_in;
         pend_blz_d  = bus.blank_lz;
         pend_flag_d = 1'b1;
      end else if (wrap && pend_flag_q) begin
         sh_val_d    = pend_val_q;
         sh_dp_d     = pend_dp_q;
         sh_blz_d    = pend_blz_q;
         pend_flag_d = 1'b0;
      end

      an_n_d        = (presc_q < GUARD_C) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
      seg_n_d       = blank_mask[idx_q] ? SEG_OFF : cur_seg_n;
      dp_n_d        = blank_mask[idx_q] | ~sh_dp_q[idx_q];
      // Delayed twice so the pulse lands with digit 0's first slot cycle on an_n.
      wrap_d        = wrap;
      frame_start_d = wrap_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q       <= '0;
         idx_q         <= '0;
         pend_val_q    <= '0;
         pend_dp_q     <= '0;
         pend_blz_q    <= 1'b0;
         pend_flag_q   <= 1'b0;
         sh_val_q      <= '0;
         sh_dp_q       <= '0;
         sh_blz_q      <= 1'b0;
         seg_n_q       <= SEG_OFF;
         dp_n_q        <= 1'b1;
         an_n_q        <= '1;
         wrap_q        <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         idx_q         <= idx_d;
         pend_val_q    <= pend_val_d;
         pend_dp_q     <= pend_dp_d;
         pend_blz_q    <= pend_blz_d;
         pend_flag_q   <= pend_flag_d;
         sh_val_q      <= sh_val_d;
         sh_dp_q       <= sh_dp_d;
         sh_blz_q      <= sh_blz_d;
         seg_n_q       <= seg_n_d;
         dp_n_q        <= dp_n_d;
         an_n_q        <= an_n_d;
         wrap_q        <= wrap_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.seg_n       = seg_n_q;
   assign bus.dp_n        = dp_n_q;
   assign bus.an_n        = an_n_q;
   assign bus.frame_start = frame_start_q;

endmodule
